pipeline_flow_ctrl: RTL and testbench

//  Hazard/flow controller driving the per-stage cond inputs of the five pipeline stages (IF, ID, EX, ME, WB).

---
 rtl/pipeline_flow_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_flow_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_flow_ctrl.sv
// rtl/pipeline_flow_ctrl.sv - hazard/flow controller driving per-stage cond for IF/ID/EX/ME/WB
module pipeline_flow_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       id_raddr1,
  input  logic [6:0]       id_raddr2,
  input  logic [6:0]       ex_waddr,
  input  logic [6:0]       me_waddr,
  input  logic [6:0]       wb_waddr,
  input  logic             mult_div_stall,
  input  logic             cal_finish,
  input  logic             overflow_stall,
  output logic [1:0]       cond_if,
  output logic [1:0]       cond_id,
  output logic [1:0]       cond_ex,
  output logic [1:0]       cond_me,
  output logic [1:0]       cond_wb,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  // Stage cond encoding shared with the pipeline parts.
  localparam logic [1:0] COND_FLOW  = 2'd0;
  localparam logic [1:0] COND_STALL = 2'd1;
  localparam logic [1:0] COND_ZERO  = 2'd2;

  // Timer only has to reach MD_TIMEOUT-1.
  localparam int TIMER_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MD_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_MD_DONE = 2'd2
  } md_state_t;

  md_state_t          state;
  md_state_t          state_next;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic               timeout_set;
  logic               raw_any;
  logic               md_hold;

  // A read target collides with a write target when both are valid and
  // name the same non-zero register (GPR0 is hardwired and never hazards).
  function automatic logic raw_hit(input logic [6:0] raddr, input logic [6:0] waddr);
    return raddr[6] & waddr[6] & (raddr[5:0] == waddr[5:0]) & (raddr[5:0] != 6'd0);
  endfunction

  // No forwarding paths: any in-flight writer of an ID source is a hazard.
  always_comb begin
    raw_any = raw_hit(id_raddr1, ex_waddr) | raw_hit(id_raddr1, me_waddr) |
              raw_hit(id_raddr1, wb_waddr) | raw_hit(id_raddr2, ex_waddr) |
              raw_hit(id_raddr2, me_waddr) | raw_hit(id_raddr2, wb_waddr);
  end

  // Front end must hold while the calculator is busy, including the very
  // first cycle a mult/div shows up without an immediate result.
  always_comb begin
    md_hold = (state == ST_MD_BUSY) ||
              ((state == ST_IDLE) && mult_div_stall && !cal_finish);
  end

  // Mult/div tracking FSM: next state, timer and timeout detection.
  always_comb begin
    state_next  = state;
    timer_next  = timer;
    timeout_set = 1'b0;
    case (state)
      ST_IDLE: begin
        // An overflowing EX instruction is squashed, so it never starts a mult/div.
        if (!overflow_stall && mult_div_stall) begin
          state_next = cal_finish ? ST_MD_DONE : ST_MD_BUSY;
        end
      end
      ST_MD_BUSY: begin
        if (overflow_stall) begin
          state_next = ST_IDLE;
          timer_next = '0;
        end else if (cal_finish) begin
          state_next = ST_MD_DONE;
          timer_next = '0;
        end else if (timer == TIMER_LAST) begin
          state_next  = ST_MD_DONE;
          timer_next  = '0;
          timeout_set = 1'b1;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end
      ST_MD_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
      end
    endcase
  end

  // FSM state and timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_timeout <= 1'b0;
    end else if (timeout_set) begin
      md_timeout <= 1'b1;
    end
  end

  // Per-stage cond, first matching rule wins.
  always_comb begin
    cond_if = COND_FLOW;
    cond_id = COND_FLOW;
    cond_ex = COND_FLOW;
    cond_me = COND_FLOW;
    cond_wb = COND_FLOW;
    if (reset) begin
      cond_if = COND_ZERO;
      cond_id = COND_ZERO;
      cond_ex = COND_ZERO;
      cond_me = COND_ZERO;
      cond_wb = COND_ZERO;
    end else if (overflow_stall) begin
      // Squash EX; ME receives the bubble, older stages drain.
      cond_if = COND_STALL;
      cond_id = COND_STALL;
      cond_ex = COND_ZERO;
    end else if (md_hold) begin
      // EX keeps the mult/div; ME gets a bubble, WB drains.
      cond_if = COND_STALL;
      cond_id = COND_STALL;
      cond_ex = COND_STALL;
      cond_me = COND_ZERO;
    end else if (raw_any) begin
      // Hold IF, push a bubble into EX while the writer retires.
      cond_if = COND_STALL;
      cond_id = COND_ZERO;
    end
  end

  // Saturating count of cycles where fetch did not advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if ((cond_if != COND_FLOW) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// tb/tb_pipeline_flow_ctrl.sv - directed self-checking bench for pipeline_flow_ctrl
module tb_pipeline_flow_ctrl;

  localparam logic [1:0] F = 2'd0;
  localparam logic [1:0] S = 2'd1;
  localparam logic [1:0] Z = 2'd2;

  logic        clk;
  logic        reset;
  logic [6:0]  id_raddr1;
  logic [6:0]  id_raddr2;
  logic [6:0]  ex_waddr;
  logic [6:0]  me_waddr;
  logic [6:0]  wb_waddr;
  logic        mult_div_stall;
  logic        cal_finish;
  logic        overflow_stall;
  logic [1:0]  cond_if;
  logic [1:0]  cond_id;
  logic [1:0]  cond_ex;
  logic [1:0]  cond_me;
  logic [1:0]  cond_wb;
  logic        md_timeout;
  logic [31:0] stall_cycles;
  logic [9:0]  conds;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_flow_ctrl #(
    .MD_TIMEOUT(40),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_raddr1(id_raddr1),
    .id_raddr2(id_raddr2),
    .ex_waddr(ex_waddr),
    .me_waddr(me_waddr),
    .wb_waddr(wb_waddr),
    .mult_div_stall(mult_div_stall),
    .cal_finish(cal_finish),
    .overflow_stall(overflow_stall),
    .cond_if(cond_if),
    .cond_id(cond_id),
    .cond_ex(cond_ex),
    .cond_me(cond_me),
    .cond_wb(cond_wb),
    .md_timeout(md_timeout),
    .stall_cycles(stall_cycles)
  );

  assign conds = {cond_if, cond_id, cond_ex, cond_me, cond_wb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] c, input logic [1:0] d,
                                     input logic [1:0] e);
    return {22'd0, a, b, c, d, e};
  endfunction

  // One clock edge, then settle away from it.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset          = 1'b1;
    id_raddr1      = 7'h00;
    id_raddr2      = 7'h00;
    ex_waddr       = 7'h00;
    me_waddr       = 7'h00;
    wb_waddr       = 7'h00;
    mult_div_stall = 1'b0;
    cal_finish     = 1'b0;
    overflow_stall = 1'b0;
    #1;
    expect_eq("reset_conds", {22'd0, conds}, pk(Z, Z, Z, Z, Z));
    expect_eq("reset_stall_cnt", stall_cycles, 32'd0);
    expect_eq("reset_md_timeout", {31'd0, md_timeout}, 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    expect_eq("idle_flow", {22'd0, conds}, pk(F, F, F, F, F));

    // T1: reset in the middle of MD_BUSY with timer at 10
    mult_div_stall = 1'b1;
    for (int i = 0; i < 11; i++) cyc();
    #1;
    expect_eq("t1_busy_stall", {22'd0, conds}, pk(S, S, S, Z, F));
    reset = 1'b1;
    #1;
    expect_eq("t1_async_zero", {22'd0, conds}, pk(Z, Z, Z, Z, Z));
    expect_eq("t1_cnt_cleared", stall_cycles, 32'd0);
    reset = 1'b0;
    mult_div_stall = 1'b0;
    #1;
    expect_eq("t1_idle_after", {22'd0, conds}, pk(F, F, F, F, F));
    cyc();
    expect_eq("t1_cnt_hold", stall_cycles, 32'd0);

    // T2: RAW on GPR5 through EX, ME, WB
    id_raddr1 = 7'h45;
    ex_waddr  = 7'h45;
    #1;
    expect_eq("t2_raw_ex", {22'd0, conds}, pk(S, Z, F, F, F));
    cyc();
    ex_waddr = 7'h00;
    me_waddr = 7'h45;
    #1;
    expect_eq("t2_raw_me", {22'd0, conds}, pk(S, Z, F, F, F));
    cyc();
    me_waddr = 7'h00;
    wb_waddr = 7'h45;
    #1;
    expect_eq("t2_raw_wb", {22'd0, conds}, pk(S, Z, F, F, F));
    cyc();
    wb_waddr = 7'h00;
    #1;
    expect_eq("t2_clear_flow", {22'd0, conds}, pk(F, F, F, F, F));
    expect_eq("t2_cnt", stall_cycles, 32'd3);

    // T3: GPR0 never hazards; HI via raddr2 does; invalid read never does
    id_raddr1 = 7'h40;
    id_raddr2 = 7'h40;
    ex_waddr  = 7'h40;
    me_waddr  = 7'h40;
    wb_waddr  = 7'h40;
    #1;
    expect_eq("t3_gpr0_flow", {22'd0, conds}, pk(F, F, F, F, F));
    cyc();
    expect_eq("t3_cnt_hold", stall_cycles, 32'd3);
    id_raddr1 = 7'h00;
    id_raddr2 = 7'h60;
    ex_waddr  = 7'h00;
    me_waddr  = 7'h60;
    wb_waddr  = 7'h00;
    #1;
    expect_eq("t3_hi_raw2", {22'd0, conds}, pk(S, Z, F, F, F));
    cyc();
    id_raddr1 = 7'h05;
    id_raddr2 = 7'h00;
    ex_waddr  = 7'h45;
    me_waddr  = 7'h00;
    #1;
    expect_eq("t3_invalid_read", {22'd0, conds}, pk(F, F, F, F, F));
    cyc();
    id_raddr1 = 7'h00;
    ex_waddr  = 7'h00;
    expect_eq("t3_cnt", stall_cycles, 32'd4);

    // T4: mult/div finishing in its 32nd stall cycle
    mult_div_stall = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cal_finish = (i == 31);
      #1;
      expect_eq($sformatf("t4_stall_%0d", i), {22'd0, conds}, pk(S, S, S, Z, F));
      cyc();
    end
    mult_div_stall = 1'b0;
    cal_finish     = 1'b0;
    #1;
    expect_eq("t4_done_flow", {22'd0, conds}, pk(F, F, F, F, F));
    cyc();
    #1;
    expect_eq("t4_idle_flow", {22'd0, conds}, pk(F, F, F, F, F));
    expect_eq("t4_cnt", stall_cycles, 32'd36);

    // Immediate finish, then back-to-back mult/div through MD_DONE
    mult_div_stall = 1'b1;
    cal_finish     = 1'b1;
    #1;
    expect_eq("b2b_immediate", {22'd0, conds}, pk(F, F, F, F, F));
    cyc();
    cal_finish = 1'b0;
    #1;
    expect_eq("b2b_done_flow", {22'd0, conds}, pk(F, F, F, F, F));
    cyc();
    #1;
    expect_eq("b2b_idle_start", {22'd0, conds}, pk(S, S, S, Z, F));
    cyc();
    cal_finish = 1'b1;
    #1;
    expect_eq("b2b_busy_fin", {22'd0, conds}, pk(S, S, S, Z, F));
    cyc();
    mult_div_stall = 1'b0;
    cal_finish     = 1'b0;
    #1;
    expect_eq("b2b_done2", {22'd0, conds}, pk(F, F, F, F, F));
    cyc();
    expect_eq("b2b_cnt", stall_cycles, 32'd38);

    // T5: calculator never finishes; timeout after 40 MD_BUSY cycles
    mult_div_stall = 1'b1;
    for (int i = 0; i < 41; i++) begin
      #1;
      expect_eq($sformatf("t5_stall_%0d", i), {22'd0, conds}, pk(S, S, S, Z, F));
      expect_eq($sformatf("t5_no_to_%0d", i), {31'd0, md_timeout}, 32'd0);
      cyc();
    end
    #1;
    expect_eq("t5_timeout_set", {31'd0, md_timeout}, 32'd1);
    expect_eq("t5_done_flow", {22'd0, conds}, pk(F, F, F, F, F));
    mult_div_stall = 1'b0;
    cyc();
    expect_eq("t5_cnt", stall_cycles, 32'd79);

    // T6: overflow dominates RAW, then RAW rule takes over
    id_raddr1      = 7'h45;
    ex_waddr       = 7'h45;
    overflow_stall = 1'b1;
    #1;
    expect_eq("t6_ovf", {22'd0, conds}, pk(S, S, Z, F, F));
    cyc();
    overflow_stall = 1'b0;
    #1;
    expect_eq("t6_raw_after", {22'd0, conds}, pk(S, Z, F, F, F));
    cyc();
    id_raddr1 = 7'h00;
    ex_waddr  = 7'h00;

    // Overflow during MD_BUSY returns the FSM to IDLE
    mult_div_stall = 1'b1;
    cyc();
    overflow_stall = 1'b1;
    #1;
    expect_eq("t6_ovf_busy", {22'd0, conds}, pk(S, S, Z, F, F));
    cyc();
    overflow_stall = 1'b0;
    mult_div_stall = 1'b0;
    #1;
    expect_eq("t6_idle_after_ovf", {22'd0, conds}, pk(F, F, F, F, F));
    cyc();
    expect_eq("t6_cnt", stall_cycles, 32'd83);
    expect_eq("sticky_timeout", {31'd0, md_timeout}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
